// File: rtl/sobel_pkg.sv
// sobel_pkg: widths and types shared by the Sobel edge detector and its bench.
// The magnitude width is derived from the sample width.
// For a 3x3 kernel with weights 1-2-1, that needs three extra bits.
package sobel_pkg;

  localparam int SOBEL_DEF_WIDTH = 8;

  // Gradient / magnitude width for a given gray sample width.
  function automatic int sobelMagWidth(input int sampleWidth);
    return sampleWidth + 3;
  endfunction

  localparam int MAG_W = sobelMagWidth(SOBEL_DEF_WIDTH);

  typedef logic [SOBEL_DEF_WIDTH-1:0] sample_t;

  // Window indexed [row][col].
  // Row 0 is the oldest line and col 0 is the oldest column.
  typedef sample_t window_t [0:2][0:2];

  typedef logic signed [MAG_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]        mag_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one line of gray samples.
// It has one write port and one asynchronous read port.
// A read and a write to the same address in the same cycle returns the old
// contents (read-before-write).
// The contents are never reset.
module sobel_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 320,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  assign o_rdata = r_mem[i_addr];

  // Store the incoming sample; the read port above still sees the old value this cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel edge detector on a streamed grayscale video.
// Timing inputs are delayed by exactly four clocks.
// o_edge/o_data are aligned with the delayed o_de.
// Optional build macro SOBEL_INVERT_EN selects the output polarity:
//   defined   -> o_data is all-zeros at edges and all-ones on other active pixels
//                (black pen on white paper); blanking stays zero.
//   undefined -> o_data is all-ones at edges and all-zeros elsewhere.
module sobel_edge
  import sobel_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IMG_WIDTH = 320,
  parameter int THRESHOLD = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_gray,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic             o_edge,
  output logic [WIDTH-1:0] o_data
);

  localparam int MW = sobelMagWidth(WIDTH);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = 12;

  localparam logic [XW-1:0] X_END = XW'(IMG_WIDTH);
  localparam logic [YW-1:0] Y_MAX = '1;
  localparam logic [31:0]   THR   = 32'(THRESHOLD);

  // Column counter (saturates at IMG_WIDTH) and row counter (saturates at its maximum).
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_dePrev;
  logic          r_vsPrev;

  logic w_deFall;
  logic w_vsRise;
  logic w_xInRange;
  logic w_winValid;

  assign w_deFall   = r_dePrev & ~i_de;
  assign w_vsRise   = i_vsync & ~r_vsPrev;
  assign w_xInRange = (r_x < X_END);
  assign w_winValid = i_de & w_xInRange & (r_x >= XW'(2)) & (r_y >= YW'(2));

  // Track pixel position.
  // x counts accepted pixels and clears when i_de falls.
  // y counts line ends.
  // A vsync rise clears y and wins over a line end in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_dePrev <= 1'b0;
      r_vsPrev <= 1'b0;
    end else begin
      r_dePrev <= i_de;
      r_vsPrev <= i_vsync;
      if (i_de) begin
        if (w_xInRange) begin
          r_x <= r_x + XW'(1);
        end
      end else if (w_deFall) begin
        r_x <= '0;
      end
      if (w_vsRise) begin
        r_y <= '0;
      end else if (w_deFall && (r_y != Y_MAX)) begin
        r_y <= r_y + YW'(1);
      end
    end
  end

  // Two line buffers hold rows y-1 and y-2.
  // Pixels beyond the line-buffer depth never write.
  logic [AW-1:0]    w_addr;
  logic             w_we;
  logic [WIDTH-1:0] w_row1;
  logic [WIDTH-1:0] w_row2;

  assign w_addr = w_xInRange ? r_x[AW-1:0] : '0;
  assign w_we   = i_de & w_xInRange;

  sobel_line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_WIDTH),
    .AW    (AW)
  ) u_lineBuf1 (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (i_gray),
    .o_rdata (w_row1)
  );

  sobel_line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_WIDTH),
    .AW    (AW)
  ) u_lineBuf2 (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_row1),
    .o_rdata (w_row2)
  );

  // 3x3 window indexed [row][col].
  // Row 2 and col 2 hold the newest samples.
  logic [WIDTH-1:0] r_win [0:2][0:2];
  logic             r_valid1;

  // On each accepted pixel, shift the window left and load the new column.
  // The new column is {row y-2, row y-1, current sample}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= w_winValid;
      if (i_de) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_row2;
        r_win[1][2] <= w_row1;
        r_win[2][2] <= i_gray;
      end
    end
  end

  function automatic logic signed [MW-1:0] tap1(input logic [WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic signed [MW-1:0] tap2(input logic [WIDTH-1:0] p);
    return $signed({2'b00, p, 1'b0});
  endfunction

  logic signed [MW-1:0] w_gx;
  logic signed [MW-1:0] w_gy;

  assign w_gx = (tap1(r_win[0][2]) + tap2(r_win[1][2]) + tap1(r_win[2][2]))
              - (tap1(r_win[0][0]) + tap2(r_win[1][0]) + tap1(r_win[2][0]));
  assign w_gy = (tap1(r_win[2][0]) + tap2(r_win[2][1]) + tap1(r_win[2][2]))
              - (tap1(r_win[0][0]) + tap2(r_win[0][1]) + tap1(r_win[0][2]));

  logic signed [MW-1:0] r_gx;
  logic signed [MW-1:0] r_gy;
  logic                 r_valid2;

  // Register both gradients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gx     <= '0;
      r_gy     <= '0;
      r_valid2 <= 1'b0;
    end else begin
      r_gx     <= w_gx;
      r_gy     <= w_gy;
      r_valid2 <= r_valid1;
    end
  end

  logic [MW-1:0] w_absX;
  logic [MW-1:0] w_absY;
  logic [MW-1:0] r_mag;
  logic          r_valid3;

  assign w_absX = r_gx[MW-1] ? -r_gx : r_gx;
  assign w_absY = r_gy[MW-1] ? -r_gy : r_gy;

  // Register the magnitude |Gx| + |Gy|.
  // Its largest value (8*max sample) still fits in MW bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag    <= '0;
      r_valid3 <= 1'b0;
    end else begin
      r_mag    <= w_absX + w_absY;
      r_valid3 <= r_valid2;
    end
  end

  // Timing delay line.
  // These three stages plus the output register give four clocks of delay.
  logic [2:0] r_vsDly;
  logic [2:0] r_hsDly;
  logic [2:0] r_deDly;

  // Shift the upstream timing alongside the pixel pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsDly <= '0;
      r_hsDly <= '0;
      r_deDly <= '0;
    end else begin
      r_vsDly <= {r_vsDly[1:0], i_vsync};
      r_hsDly <= {r_hsDly[1:0], i_hsync};
      r_deDly <= {r_deDly[1:0], i_de};
    end
  end

  logic             w_isEdge;
  logic             r_vsync;
  logic             r_hsync;
  logic             r_de;
  logic             r_edge;
  logic [WIDTH-1:0] r_data;

  assign w_isEdge = r_valid3 & ({{(32-MW){1'b0}}, r_mag} > THR);

  // Output register.
  // The edge decision is strict (equal to the threshold is not an edge).
  // Data is forced to zero whenever the delayed de is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_de    <= 1'b0;
      r_edge  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_vsync <= r_vsDly[2];
      r_hsync <= r_hsDly[2];
      r_de    <= r_deDly[2];
      r_edge  <= r_deDly[2] & w_isEdge;
`ifdef SOBEL_INVERT_EN
      r_data  <= (r_deDly[2] & ~w_isEdge) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
`else
      r_data  <= (r_deDly[2] & w_isEdge) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
`endif
    end
  end

  assign o_vsync = r_vsync;
  assign o_hsync = r_hsync;
  assign o_de    = r_de;
  assign o_edge  = r_edge;
  assign o_data  = r_data;

endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: directed frames with an expectation queue for sobel_edge.
// Each driven cycle pushes the expected output.
// The entry is compared four clocks later.
// The reference computes Sobel directly from the synthetic image.
module tb_sobel_edge;
  import sobel_pkg::*;

  localparam int WIDTH = 8;
  localparam int IMG_W = 8;
  localparam int THR   = 64;

  typedef enum int {FLAT, VSTEP, THR16, THR17, HSTEP} img_kind_e;

  typedef struct packed {
    logic             vs;
    logic             hs;
    logic             de;
    logic             edg;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_vsync = 1'b0;
  logic             i_hsync = 1'b0;
  logic             i_de = 1'b0;
  logic [WIDTH-1:0] i_gray = '0;
  logic             o_vsync;
  logic             o_hsync;
  logic             o_de;
  logic             o_edge;
  logic [WIDTH-1:0] o_data;

  exp_t  expQ[$];
  string tagQ[$];
  int    assertCount = 0;
  int    failCount = 0;

  always #5 clk = ~clk;

  sobel_edge #(
    .WIDTH     (WIDTH),
    .IMG_WIDTH (IMG_W),
    .THRESHOLD (THR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_vsync (i_vsync),
    .i_hsync (i_hsync),
    .i_de    (i_de),
    .i_gray  (i_gray),
    .o_vsync (o_vsync),
    .o_hsync (o_hsync),
    .o_de    (o_de),
    .o_edge  (o_edge),
    .o_data  (o_data)
  );

  function automatic int pixelValue(img_kind_e k, int x, int y);
    case (k)
      FLAT:    return 100;
      VSTEP:   return (x < 4) ? 0 : ((x < 8) ? 255 : 0);
      THR16:   return (x < 4) ? 50 : 66;
      THR17:   return (x < 4) ? 50 : 67;
      HSTEP:   return (y < 4) ? 0 : 200;
      default: return 0;
    endcase
  endfunction

  function automatic logic expectEdge(img_kind_e k, int x, int y);
    window_t w;
    grad_t   gx;
    grad_t   gy;
    int      ax;
    int      ay;
    if (x < 2 || y < 2 || x >= IMG_W) return 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[r][c] = sample_t'(pixelValue(k, x - 2 + c, y - 2 + r));
      end
    end
    gx = grad_t'((int'(w[0][2]) + 2 * int'(w[1][2]) + int'(w[2][2]))
               - (int'(w[0][0]) + 2 * int'(w[1][0]) + int'(w[2][0])));
    gy = grad_t'((int'(w[2][0]) + 2 * int'(w[2][1]) + int'(w[2][2]))
               - (int'(w[0][0]) + 2 * int'(w[0][1]) + int'(w[0][2])));
    ax = (int'(gx) < 0) ? -int'(gx) : int'(gx);
    ay = (int'(gy) < 0) ? -int'(gy) : int'(gy);
    return (ax + ay) > THR;
  endfunction

  function automatic exp_t makeExp(logic vs, logic hs, logic de, logic edg);
    exp_t e;
    e.vs  = vs;
    e.hs  = hs;
    e.de  = de;
    e.edg = de & edg;
`ifdef SOBEL_INVERT_EN
    e.data = (de && !e.edg) ? 8'hFF : 8'h00;
`else
    e.data = (de && e.edg) ? 8'hFF : 8'h00;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string tag, input exp_t e);
    exp_t got;
    got = {o_vsync, o_hsync, o_de, o_edge, o_data};
    assertCount++;
    assert (got === e) else begin
      failCount++;
      $error("[TB] FAIL %s: observed vs=%0b hs=%0b de=%0b edge=%0b data=%h, expected vs=%0b hs=%0b de=%0b edge=%0b data=%h",
             tag, got.vs, got.hs, got.de, got.edg, got.data, e.vs, e.hs, e.de, e.edg, e.data);
    end
  endtask

  // Drive one cycle, record its expectation, and check the entry from four clocks ago.
  task automatic applyStimulus(input logic vs, input logic hs, input logic de,
                               input int gray, input logic edg, input string tag);
    exp_t  e;
    string t;
    i_vsync = vs;
    i_hsync = hs;
    i_de    = de;
    i_gray  = WIDTH'(gray);
    expQ.push_back(makeExp(vs, hs, de, edg));
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    if (expQ.size() == 4) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput(t, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, "blank");
  endtask

  task automatic frameStart();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, "vsync");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, "vsync");
    idle(2);
  endtask

  // Mid-line reset: outputs must clear at once without a clock edge.
  task automatic midFrameReset();
    exp_t z;
    z       = '0;
    rst     = 1'b1;
    i_vsync = 1'b0;
    i_hsync = 1'b0;
    i_de    = 1'b0;
    i_gray  = '0;
    #1;
    checkOutput("rst_async_clear", z);
    expQ.delete();
    tagQ.delete();
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic driveRow(input img_kind_e k, input int y, input int nCols,
                          input int gapAt, input int abortAt, input logic vsTrail);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, "hsync");
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, "hblank");
    for (int x = 0; x < nCols; x++) begin
      if (x == gapAt) begin
        for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, "de_gap");
      end
      applyStimulus(1'b0, 1'b0, 1'b1, pixelValue(k, x, y), expectEdge(k, x, y),
                    $sformatf("%s y%0d x%0d", k.name(), y, x));
      if (x == abortAt) begin
        midFrameReset();
        return;
      end
    end
    applyStimulus(vsTrail, 1'b0, 1'b0, 0, 1'b0, "trail");
    applyStimulus(vsTrail, 1'b0, 1'b0, 0, 1'b0, "trail");
  endtask

  initial begin
    exp_t z;
    z = '0;
    $display("[TB] sobel_edge bench start");

    // Reset held with busy inputs: all outputs must stay at zero.
    rst     = 1'b1;
    i_vsync = 1'b1;
    i_hsync = 1'b1;
    i_de    = 1'b1;
    i_gray  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", z);
    i_vsync = 1'b0;
    i_hsync = 1'b0;
    i_de    = 1'b0;
    i_gray  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);

    // Flat field: no edges anywhere.
    frameStart();
    for (int y = 0; y < 8; y++) driveRow(FLAT, y, 8, -1, -1, 1'b0);

    // Vertical step, with two extra pixels per line beyond the buffer depth.
    frameStart();
    for (int y = 0; y < 8; y++) driveRow(VSTEP, y, 10, -1, -1, 1'b0);

    // Threshold boundary: magnitude 64 is not an edge, 68 is.
    frameStart();
    for (int y = 0; y < 8; y++) driveRow(THR16, y, 8, -1, -1, 1'b0);
    frameStart();
    for (int y = 0; y < 8; y++) driveRow(THR17, y, 8, -1, -1, 1'b0);

    // Three-cycle de gap mid-line must be reproduced on o_de.
    frameStart();
    for (int y = 0; y < 8; y++) driveRow(FLAT, y, 8, (y == 3) ? 4 : -1, -1, 1'b0);

    // Horizontal step; the last line end coincides with a vsync rise.
    frameStart();
    for (int y = 0; y < 8; y++) driveRow(HSTEP, y, 8, -1, -1, (y == 7) ? 1'b1 : 1'b0);
    frameStart();
    for (int y = 0; y < 8; y++) driveRow(VSTEP, y, 8, -1, -1, 1'b0);

    // Reset during row 5.
    // Lines after release restart at y=0 even without a vsync.
    frameStart();
    for (int y = 0; y < 5; y++) driveRow(VSTEP, y, 8, -1, -1, 1'b0);
    driveRow(VSTEP, 5, 8, -1, 7, 1'b0);
    for (int y = 0; y < 3; y++) driveRow(VSTEP, y, 8, -1, -1, 1'b0);
    frameStart();
    for (int y = 0; y < 4; y++) driveRow(VSTEP, y, 8, -1, -1, 1'b0);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Safety bound against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no completion, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 SHALL have parameter WIDTH, default 8, gray sample width.
REQ-002 SHALL have parameter IMG_WIDTH, default 320, maximum active pixels per line.
REQ-003 SHALL have parameter THRESHOLD, default 64, edge decision level on gradient magnitude.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports i_vsync, i_hsync, i_de  input  1 each  upstream grayscale stage timing.
REQ-007 SHALL have port i_gray  input  WIDTH  gray sample, valid when i_de=1.
REQ-008 SHALL have ports o_vsync, o_hsync, o_de  output  1 each  delayed timing.
REQ-009 SHALL have port o_edge  output  1  edge flag for the delayed pixel.
REQ-010 SHALL have port o_data  output  WIDTH  monochrome pixel, all-ones or all-zeros.

Function
REQ-011 SHALL keep column counter x: +1 per i_de=1 cycle; cleared on i_de falling edge.
REQ-012 SHALL keep row counter y: +1 on i_de falling edge; cleared on i_vsync rising edge.
REQ-013 SHALL hold two line buffers, depth IMG_WIDTH; per accepted pixel, read rows y-1, y-2 at x before writing (read-before-write).
REQ-014 SHALL shift a 3x3 window per accepted pixel; the window at input (x,y) is centred on (x-1,y-1).
REQ-015 SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20) and Gy=(p20+2p21+p22)-(p00+2p01+p02), signed, WIDTH+3 bits, no overflow.
REQ-016 SHALL compute magnitude |Gx|+|Gy|, unsigned WIDTH+3 bits (max 2040 at WIDTH=8).
REQ-017 SHALL set o_edge=1 when magnitude > THRESHOLD (strict); equal is non-edge.
REQ-018 SHALL force o_edge=0 when x<2 or y<2 (incomplete window).
REQ-019 SHALL force o_edge=0 and skip buffer writes for pixels with x >= IMG_WIDTH.
REQ-020 SHALL set o_data all-ones when o_edge=1, else all-zeros.
REQ-021 SHALL delay o_vsync, o_hsync, o_de exactly 4 clocks from the inputs; o_edge/o_data aligned with o_de.
REQ-022 SHALL drive o_edge=0, o_data=0 whenever o_de=0.
REQ-023 SHALL preserve i_de gaps and blanking cycle-for-cycle; no back-pressure, no stalls.
REQ-024 SHALL let i_vsync rising edge and i_de falling edge in the same cycle both apply (y cleared takes priority over increment).

Reset
REQ-025 SHALL, while rst=1, immediately force all outputs, counters, window and pipeline registers to 0.
REQ-026 SHALL not reset line-buffer contents; REQ-018 masks stale data.
REQ-027 SHALL, after rst mid-frame, treat the next active line as y=0 until the following i_vsync rising edge re-aligns.

Configuration
REQ-028 SHALL honour macro SOBEL_INVERT_EN: when defined, o_data is all-zeros for edge and all-ones for non-edge active pixels (pen lines black on white); blanking still 0; o_edge unchanged.
REQ-029 SHALL, without SOBEL_INVERT_EN, behave per REQ-020.

Structure
REQ-030 SHALL place in shared package sobel_pkg: constant MAG_W=WIDTH+3 derivation, typedef for a 3x3 window of WIDTH-bit samples, typedef for signed gradient.
REQ-031 SHALL instantiate sub-module sobel_line_buffer (one write port, one read port, depth IMG_WIDTH) twice.

Verification
REQ-032 SHALL cover flat field: 8x8 frame, i_gray=100 everywhere -> o_edge=0, o_data=0x00 for all 64 pixels.
REQ-033 SHALL cover vertical step: columns 0-3=0, 4-7=255 -> o_edge=1 only for centres x=3,4 on rows y>=1, magnitude 1020.
REQ-034 SHALL cover threshold boundary: step height 16 (magnitude 64) -> o_edge=0; step 17 (magnitude 68) -> o_edge=1.
REQ-035 SHALL cover latency: i_vsync pulse at cycle t -> o_vsync at t+4; 3-cycle i_de gap mid-line reproduced on o_de.
REQ-036 SHALL cover reset mid-frame: rst=1 during row 5 -> outputs 0 same cycle; after release and next vsync, rows 0-1 give o_edge=0.
REQ-037 SHALL cover SOBEL_INVERT_EN build: vertical-step frame -> o_data=0x00 at edges, 0xFF elsewhere in active area, 0x00 in blanking.
